// File: rtl/demux2_32_if.sv
// ============================================================================
//  Module      : demux2_32_if
//  Description : Bus bundle for the 2-way, 32-bit valid/ready demultiplexer.
//                One upstream channel with a route select, two downstream
//                channels. The per-port delivered-word counters are present
//                only when DEMUX2_32_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface demux2_32_if;
    // Upstream channel
    logic [31:0] in_data;
    logic        s0;
    logic        in_v;
    logic        in_r;
    // Downstream port 0
    logic [31:0] y0;
    logic        y0_v;
    logic        y0_r;
    // Downstream port 1
    logic [31:0] y1;
    logic        y1_v;
    logic        y1_r;
`ifdef DEMUX2_32_CNT_EN
    // Delivered-word counters
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    // Demultiplexer side
    modport slave (
        input  in_data, s0, in_v, y0_r, y1_r,
`ifdef DEMUX2_32_CNT_EN
        output cnt0, cnt1,
`endif
        output in_r, y0, y0_v, y1, y1_v
    );

    // Producer / consumer side
    modport master (
        output in_data, s0, in_v, y0_r, y1_r,
`ifdef DEMUX2_32_CNT_EN
        input  cnt0, cnt1,
`endif
        input  in_r, y0, y0_v, y1, y1_v
    );
endinterface

`default_nettype wire

// File: rtl/demux2_32.sv
// ============================================================================
//  Module      : demux2_32
//  Description : 2-way, 32-bit valid/ready demultiplexer. Each accepted word
//                is steered by s0 into a single-entry output register (R0/R1)
//                with its own valid flag. A port accepts a new word in the
//                same cycle it delivers, so each port sustains one word per
//                cycle. Optional 16-bit delivered-word counters per port are
//                built when DEMUX2_32_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux2_32 (
    input  wire logic   clk,
    input  wire logic   rst_n,
    demux2_32_if.slave  bus
);

    // Output stage state
    logic [31:0] r_data0;
    logic [31:0] r_data1;
    logic        r_v0;
    logic        r_v1;

    // Handshake decode
    logic        w_in_r;
    logic        w_acc;
    logic        w_ld0;
    logic        w_ld1;
    logic        w_dlv0;
    logic        w_dlv1;

    // Upstream is ready when the selected port is empty or draining this cycle
    always_comb begin
        w_in_r = 1'b0;
        w_acc  = 1'b0;
        w_ld0  = 1'b0;
        w_ld1  = 1'b0;
        w_dlv0 = r_v0 & bus.y0_r;
        w_dlv1 = r_v1 & bus.y1_r;
        if (bus.s0) begin
            w_in_r = ~r_v1 | bus.y1_r;
        end else begin
            w_in_r = ~r_v0 | bus.y0_r;
        end
        // Select only matters on an accepted transfer, so gating by w_acc
        // keeps s0 and in_data don't-care while in_v is low.
        w_acc = bus.in_v & w_in_r;
        w_ld0 = w_acc & ~bus.s0;
        w_ld1 = w_acc &  bus.s0;
    end

    // Port registers: load wins over deliver so a same-cycle refill keeps valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data0 <= 32'd0;
            r_data1 <= 32'd0;
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
        end else begin
            if (w_ld0) begin
                r_data0 <= bus.in_data;
                r_v0    <= 1'b1;
            end else if (w_dlv0) begin
                r_v0    <= 1'b0;
            end
            if (w_ld1) begin
                r_data1 <= bus.in_data;
                r_v1    <= 1'b1;
            end else if (w_dlv1) begin
                r_v1    <= 1'b0;
            end
        end
    end

`ifdef DEMUX2_32_CNT_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    // Count delivered words per port; natural 16-bit wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= 16'd0;
            r_cnt1 <= 16'd0;
        end else begin
            if (w_dlv0) begin
                r_cnt0 <= r_cnt0 + 16'd1;
            end
            if (w_dlv1) begin
                r_cnt1 <= r_cnt1 + 16'd1;
            end
        end
    end

    assign bus.cnt0 = r_cnt0;
    assign bus.cnt1 = r_cnt1;
`endif

    assign bus.in_r = w_in_r;
    assign bus.y0   = r_data0;
    assign bus.y0_v = r_v0;
    assign bus.y1   = r_data1;
    assign bus.y1_v = r_v1;

endmodule

`default_nettype wire
